// File: rtl/mem_arbiter.sv
// Shares one unified memory between the MIPS core and an external port.
// Core has priority; external side gets a wait-forced bounded burst.
module mem_arbiter #(
   parameter int WIDTH     = 32,
   parameter int MAX_WAIT  = 4,
   parameter int MAX_BURST = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             cpu_req,
   input  logic             cpu_we,
   input  logic [WIDTH-1:0] cpu_adr,
   input  logic [WIDTH-1:0] cpu_wd,
   output logic [WIDTH-1:0] cpu_rd,
   output logic             cpu_stall,
   input  logic             ext_req,
   input  logic             ext_we,
   input  logic [WIDTH-1:0] ext_adr,
   input  logic [WIDTH-1:0] ext_wd,
   output logic [WIDTH-1:0] ext_rd,
   output logic             ext_gnt,
   output logic             mem_we,
   output logic [WIDTH-1:0] mem_a,
   output logic [WIDTH-1:0] mem_wd,
   input  logic [WIDTH-1:0] mem_rd
);

   localparam int WW = $clog2(MAX_WAIT + 1);
   localparam int BW = $clog2(MAX_BURST + 1);
   localparam logic [WW-1:0] WAIT_TOP  = WW'(MAX_WAIT);
   localparam logic [BW-1:0] BURST_TOP = BW'(MAX_BURST);

   typedef enum logic {NORMAL, BURST} state_t;

   state_t        state, state_nxt;
   logic [WW-1:0] ext_wait, wait_nxt;
   logic [BW-1:0] burst_cnt, burst_nxt;
   logic          forced, burst_gnt, cpu_gnt;

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= NORMAL;
         ext_wait  <= '0;
         burst_cnt <= '0;
      end else begin
         state     <= state_nxt;
         ext_wait  <= wait_nxt;
         burst_cnt <= burst_nxt;
      end
   end

   always_comb begin
      forced    = 1'b0;
      burst_gnt = 1'b0;
      ext_gnt   = 1'b0;
      cpu_gnt   = 1'b0;
      state_nxt = state;
      wait_nxt  = ext_wait;
      burst_nxt = burst_cnt;
      if (!reset) begin
         // inside a burst the wait counter is already zero
         unique case (state)
            NORMAL:  forced = ext_req && (ext_wait == WAIT_TOP);
            BURST:   burst_gnt = ext_req && (burst_cnt < BURST_TOP);
            default: ;
         endcase
         ext_gnt = forced | burst_gnt | (ext_req & ~cpu_req);
         cpu_gnt = cpu_req & ~ext_gnt;
         if (forced) begin
            state_nxt = BURST;
            burst_nxt = BW'(1);
         end else if (burst_gnt) begin
            state_nxt = BURST;
            burst_nxt = burst_cnt + BW'(1);
         end else begin
            state_nxt = NORMAL;
            burst_nxt = '0;
         end
         if (ext_req && !ext_gnt) begin
            if (ext_wait != WAIT_TOP)
               wait_nxt = ext_wait + WW'(1);
         end else begin
            wait_nxt = '0;
         end
      end
   end

   assign cpu_stall = cpu_req & ~cpu_gnt & ~reset;
   assign mem_we    = (cpu_gnt & cpu_we) | (ext_gnt & ext_we);
   assign mem_a     = ext_gnt ? ext_adr : cpu_adr;
   assign mem_wd    = ext_gnt ? ext_wd : cpu_wd;
   assign cpu_rd    = mem_rd;
   assign ext_rd    = mem_rd;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: vector table, hand sequences and random traffic
// against a counter-based reference model on two parameter sets.
module tb_mem_arbiter;

   typedef struct {
      logic        r, c, cw;
      logic [31:0] ca, cd;
      logic        e, ew;
      logic [31:0] ea, ed;
      logic        xg, xs, xw;
      logic [31:0] xa;
      logic        rdck;
      logic [31:0] xrd;
   } vec_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst = 1'b1, creq = 1'b0, cwe = 1'b0;
   logic        ereq = 1'b0, ewe = 1'b0;
   logic [31:0] cadr = '0, cwd = '0, eadr = '0, ewd = '0;

   logic [31:0] crd[2], erd[2], ma[2], mwd[2], mrd[2];
   logic        stall[2], egnt[2], mwe[2];
   logic [31:0] mem1[256], mem2[256];

   int checks = 0, errors = 0, wr80 = 0, cyc = 0;
   int mwv[2] = '{4, 1};
   int mbv[2] = '{2, 1};
   int w[2] = '{0, 0};
   int b[2] = '{0, 0};

   mem_arbiter #(.WIDTH(32), .MAX_WAIT(4), .MAX_BURST(2)) u0 (
      .clk(clk), .reset(rst),
      .cpu_req(creq), .cpu_we(cwe), .cpu_adr(cadr), .cpu_wd(cwd),
      .cpu_rd(crd[0]), .cpu_stall(stall[0]),
      .ext_req(ereq), .ext_we(ewe), .ext_adr(eadr), .ext_wd(ewd),
      .ext_rd(erd[0]), .ext_gnt(egnt[0]),
      .mem_we(mwe[0]), .mem_a(ma[0]), .mem_wd(mwd[0]), .mem_rd(mrd[0])
   );

   mem_arbiter #(.WIDTH(32), .MAX_WAIT(1), .MAX_BURST(1)) u1 (
      .clk(clk), .reset(rst),
      .cpu_req(creq), .cpu_we(cwe), .cpu_adr(cadr), .cpu_wd(cwd),
      .cpu_rd(crd[1]), .cpu_stall(stall[1]),
      .ext_req(ereq), .ext_we(ewe), .ext_adr(eadr), .ext_wd(ewd),
      .ext_rd(erd[1]), .ext_gnt(egnt[1]),
      .mem_we(mwe[1]), .mem_a(ma[1]), .mem_wd(mwd[1]), .mem_rd(mrd[1])
   );

   assign mrd[0] = mem1[ma[0][9:2]];
   assign mrd[1] = mem2[ma[1][9:2]];

   always @(posedge clk) begin
      if (mwe[0]) mem1[ma[0][9:2]] <= mwd[0];
      if (mwe[1]) mem2[ma[1][9:2]] <= mwd[1];
      if (mwe[1] && ma[1] == 32'h80) wr80 <= wr80 + 1;
   end

   task automatic chk(string n, logic [31:0] a, logic [31:0] e);
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL c%0d %s: got %h expected %h", cyc, n, a, e);
      end
   endtask

   task automatic chkb(string n, logic a, logic e);
      chk(n, {31'b0, a}, {31'b0, e});
   endtask

   function automatic vec_t V(
      logic r, logic c, logic cw, logic [31:0] ca, logic [31:0] cd,
      logic e, logic ew, logic [31:0] ea, logic [31:0] ed,
      logic xg, logic xs, logic xw, logic [31:0] xa,
      logic rdck = 1'b0, logic [31:0] xrd = 32'h0);
      vec_t v;
      v.r = r; v.c = c; v.cw = cw; v.ca = ca; v.cd = cd;
      v.e = e; v.ew = ew; v.ea = ea; v.ed = ed;
      v.xg = xg; v.xs = xs; v.xw = xw; v.xa = xa;
      v.rdck = rdck; v.xrd = xrd;
      return v;
   endfunction

   // tab = 0: model only; tab = k+1: also compare DUT k with the vector
   task automatic cycle(input int tab, input vec_t v);
      bit mf[2], mb[2], meg[2], mcg[2];
      rst = v.r; creq = v.c; cwe = v.cw; cadr = v.ca; cwd = v.cd;
      ereq = v.e; ewe = v.ew; eadr = v.ea; ewd = v.ed;
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
         mf[k] = b[k] == 0 && w[k] == mwv[k] && ereq;
         mb[k] = b[k] > 0 && b[k] < mbv[k] && ereq;
         meg[k] = !rst && (mf[k] || mb[k] || (ereq && !creq));
         mcg[k] = !rst && creq && !meg[k];
         chkb($sformatf("d%0d ext_gnt", k), egnt[k], meg[k]);
         chkb($sformatf("d%0d cpu_stall", k), stall[k],
              creq && !mcg[k] && !rst);
         chkb($sformatf("d%0d mem_we", k), mwe[k],
              (mcg[k] && cwe) || (meg[k] && ewe));
         chk($sformatf("d%0d mem_a", k), ma[k], meg[k] ? eadr : cadr);
         chk($sformatf("d%0d mem_wd", k), mwd[k], meg[k] ? ewd : cwd);
      end
      if (tab > 0) begin
         int k = tab - 1;
         chkb($sformatf("tab d%0d ext_gnt", k), egnt[k], v.xg);
         chkb($sformatf("tab d%0d cpu_stall", k), stall[k], v.xs);
         chkb($sformatf("tab d%0d mem_we", k), mwe[k], v.xw);
         chk($sformatf("tab d%0d mem_a", k), ma[k], v.xa);
         if (v.rdck) begin
            chk($sformatf("tab d%0d ext_rd", k), erd[k], v.xrd);
            chk($sformatf("tab d%0d cpu_rd", k), crd[k], v.xrd);
         end
      end
      @(posedge clk);
      for (int k = 0; k < 2; k++) begin
         if (rst) begin
            w[k] = 0;
            b[k] = 0;
         end else begin
            b[k] = mf[k] ? 1 : (mb[k] ? b[k] + 1 : 0);
            if (ereq && !meg[k]) w[k] = (w[k] < mwv[k]) ? w[k] + 1 : w[k];
            else w[k] = 0;
         end
      end
      #1;
      cyc++;
   endtask

   initial begin
      vec_t q[$];
      vec_t sat[$];
      vec_t v;
      int n0;
      logic g;

      // reset with both writing, release, solo traffic
      q.push_back(V(1, 1, 1, 'h20, 1, 1, 1, 'h24, 2, 0, 0, 0, 'h20));
      q.push_back(V(1, 1, 1, 'h20, 1, 1, 1, 'h24, 2, 0, 0, 0, 'h20));
      q.push_back(V(0, 1, 1, 'h10, 'hDEADBEEF, 1, 0, 'h30, 0,
                    0, 0, 1, 'h10));
      q.push_back(V(0, 0, 0, 'h10, 0, 1, 0, 'h10, 0, 1, 0, 0, 'h10,
                    1, 'hDEADBEEF));
      q.push_back(V(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      // continuous contention
      for (int i = 0; i < 12; i++) begin
         g = (i == 4 || i == 5 || i == 10 || i == 11);
         q.push_back(V(0, 1, 0, 'h40, 0, 1, 0, 'h44, 0,
                       g, g, 0, g ? 32'h44 : 32'h40));
      end
      q.push_back(V(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      // early burst end, then a full wait before the next force
      for (int i = 0; i < 5; i++) begin
         g = (i == 4);
         q.push_back(V(0, 1, 0, 'h40, 0, 1, 0, 'h44, 0,
                       g, g, 0, g ? 32'h44 : 32'h40));
      end
      q.push_back(V(0, 1, 0, 'h40, 0, 0, 0, 'h44, 0, 0, 0, 0, 'h40));
      for (int i = 0; i < 5; i++) begin
         g = (i == 4);
         q.push_back(V(0, 1, 0, 'h40, 0, 1, 0, 'h44, 0,
                       g, g, 0, g ? 32'h44 : 32'h40));
      end
      q.push_back(V(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      // reset in cycle 5 of contention, both sides writing
      for (int i = 0; i < 5; i++) begin
         g = (i == 4);
         q.push_back(V(0, 1, 1, 'h48, 'h11, 1, 1, 'h4C, 'h22,
                       g, g, 1, g ? 32'h4C : 32'h48));
      end
      q.push_back(V(1, 1, 1, 'h48, 'h11, 1, 1, 'h4C, 'h22, 0, 0, 0, 'h48));
      for (int i = 0; i < 5; i++) begin
         g = (i == 4);
         q.push_back(V(0, 1, 1, 'h48, 'h11, 1, 1, 'h4C, 'h22,
                       g, g, 1, g ? 32'h4C : 32'h48));
      end

      // saturation on the MAX_WAIT=1, MAX_BURST=1 instance
      sat.push_back(V(1, 1, 0, 'h90, 0, 1, 0, 'h84, 0, 0, 0, 0, 'h90));
      sat.push_back(V(0, 1, 0, 'h90, 0, 1, 0, 'h84, 0, 0, 0, 0, 'h90));
      sat.push_back(V(0, 1, 1, 'h80, 'hA5A5, 1, 0, 'h84, 0,
                      1, 1, 0, 'h84));
      sat.push_back(V(0, 1, 1, 'h80, 'hA5A5, 1, 0, 'h84, 0,
                      0, 0, 1, 'h80));
      sat.push_back(V(0, 1, 0, 'h90, 0, 1, 0, 'h84, 0, 1, 1, 0, 'h84));
      sat.push_back(V(0, 1, 0, 'h90, 0, 1, 0, 'h84, 0, 0, 0, 0, 'h90));

      @(posedge clk);
      #1;
      foreach (q[i]) cycle(1, q[i]);

      n0 = wr80;
      foreach (sat[i]) cycle(2, sat[i]);
      chk("sat write count", wr80 - n0, 1);
      chk("sat mem[0x80]", mem2[32], 32'hA5A5);

      for (int i = 0; i < 400; i++) begin
         v = V($urandom_range(0, 31) == 0, $urandom_range(0, 3) != 0,
               1'($urandom), $urandom & 32'h3FC, $urandom,
               $urandom_range(0, 2) != 0, 1'($urandom),
               $urandom & 32'h3FC, $urandom, 0, 0, 0, 0);
         cycle(0, v);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter that shares the single unified instruction/data memory between the multicycle MIPS core and one external requester (program loader / debug DMA). It sits between the core's address/write-data path and the memory. The core has fixed priority; the external port has a starvation guard and a bounded burst. A core request that loses arbitration raises `cpu_stall`. The core controller freezes its state and gates `pcen`, `irwrite` and `regwrite` while `cpu_stall` is high.

## Interface
- `WIDTH`, 32: data and address width.
- `MAX_WAIT`, 4: consecutive denied external cycles before the external port is forced in (≥1).
- `MAX_BURST`, 2: maximum consecutive forced external grants (≥1).

Ports:
- `clk` input 1: single clock, rising edge.
- `reset` input 1: synchronous, active-high.
- `cpu_req` input 1: core accesses memory this cycle (fetch, load or store state).
- `cpu_we` input 1: core write.
- `cpu_adr` input WIDTH: core byte address.
- `cpu_wd` input WIDTH: core write data.
- `cpu_rd` output WIDTH: read data to core.
- `cpu_stall` output 1: core request denied this cycle.
- `ext_req` input 1: external access request.
- `ext_we` input 1: external write.
- `ext_adr` input WIDTH: external byte address.
- `ext_wd` input WIDTH: external write data.
- `ext_rd` output WIDTH: read data to external port.
- `ext_gnt` output 1: external access performed this cycle.
- `mem_we` output 1: memory write enable.
- `mem_a` output WIDTH: memory address.
- `mem_wd` output WIDTH: memory write data.
- `mem_rd` input WIDTH: memory combinational read data.

## Operation
- **Grant is combinational.** It is computed from the current state and the requests; exactly one side or neither is granted per cycle.
- **Memory mux.** `mem_a`/`mem_wd` come from the granted side, or from the core if neither is granted.
- **Write enable.** `mem_we` = the granted side's `we`; it is 0 if nothing is granted.
- **Read data.** `cpu_rd` = `ext_rd` = `mem_rd` unconditionally. Each side consumes read data only in its granted cycle.
- **Stall.** `cpu_stall` = `cpu_req & ~cpu_gnt`. The core must hold `cpu_req`/`cpu_we`/`cpu_adr`/`cpu_wd` stable while stalled.
- **State NORMAL.** Grant order:
  1. External, if `ext_wait == MAX_WAIT` and `ext_req` (forced grant).
  2. Otherwise the core, if `cpu_req`.
  3. Otherwise external, if `ext_req`.
- **State BURST**, counter `burst_cnt`:
  - If `ext_req` and `burst_cnt < MAX_BURST`: grant external.
  - Otherwise: arbitrate as NORMAL with `ext_wait` treated as 0.
- **`ext_wait` update** (each edge, saturating at MAX_WAIT):
  - +1 if `ext_req & ~ext_gnt`.
  - Cleared if `ext_gnt` or `~ext_req`.
- **Transitions:**
  - NORMAL → BURST on a forced grant; `burst_cnt` ← 1 and `ext_wait` ← 0.
  - BURST stays BURST on each further external grant; `burst_cnt` increments.
  - BURST → NORMAL in any cycle that is not a BURST external grant, i.e. `ext_req` low or `burst_cnt == MAX_BURST`. `burst_cnt` ← 0, and `ext_wait` updates by the normal rule.
- **Uncontended grants.** An external grant in NORMAL without forcing does not enter BURST.

## Timing
- **Zero latency.** A request and its grant occur in the same cycle. A write commits at the next rising edge; read data is valid in the same cycle.
- **Reset.** While `reset` is high, all grants are suppressed: `mem_we`=0, `ext_gnt`=0, `cpu_stall`=0. At the edge: state ← NORMAL, `ext_wait` ← 0, `burst_cnt` ← 0. The first arbitration is in the cycle after reset deasserts. Reset asserted mid-burst abandons the burst with no memory write.
- **Counter widths.** Counters are `$clog2(MAX+1)` bits and never wrap.
- **Guarantees under continuous contention:**
  - The external port is served MAX_BURST of every MAX_WAIT+MAX_BURST cycles.
  - The core is never stalled more than MAX_BURST consecutive cycles.
  - The external port never waits more than MAX_WAIT cycles.
- **Simultaneous writes.** Two writes in one cycle are impossible; only the granted write reaches `mem_we`.

## Test plan
- **Reset.** Hold `reset`=1 with both ports requesting writes → `mem_we`=0, `ext_gnt`=0, `cpu_stall`=0 every cycle. After release, the first cycle grants the core.
- **Solo traffic.**
  - Core only, `cpu_adr`=0x10, `cpu_we`=1, `cpu_wd`=0xDEADBEEF → `mem_we`=1, `mem_a`=0x10, no stall.
  - External only, read of 0x10 → `ext_gnt`=1, `ext_rd`=0xDEADBEEF.
- **Continuous contention** (defaults MAX_WAIT=4, MAX_BURST=2), both requesting from cycle 0:
  - Core granted in cycles 0–3, external in 4–5, core in 6–9, external in 10–11.
  - `cpu_stall` is high exactly in 4, 5, 10 and 11.
- **Early burst end.** Both request; after the forced grant in cycle 4, `ext_req` drops in cycle 5 → state returns to NORMAL, the core is granted in cycle 5, and `ext_wait`=0.
- **Reset mid-burst.** Assert `reset` in cycle 5 of the contention scenario → no write in cycle 5. After release, the core is granted first and external forcing recurs only after 4 more denied cycles.
- **Saturation.** MAX_WAIT=1, MAX_BURST=1 under contention → grants alternate core/external every cycle. The stalled core write commits exactly once, when granted.
